gaussian_filter_3x3: RTL and testbench

Streaming 3x3 Gaussian blur stage placed directly downstream of crop_filter. It consumes the raster-ordered cropped window (OUT_ROWS x OUT_COLS) over the pixel AXI-stream. It emits the valid-region convolution ((ROWS-2) x (COLS-2)) with kernel [1 2 1; 2 4 2; 1 2 1]/16. Two line buffers plus a 3x3 window register give one output per accepted input once the window is primed.

---
 rtl/gaussian_filter_3x3_if.sv | 23 ++
 rtl/gaussian_filter_3x3.sv | 135 +++++++++++++
 tb/tb_gaussian_filter_3x3.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_filter_3x3_if.sv
// Pixel stream bundle for the 3x3 Gaussian stage: input AXI-stream slave side
// and output AXI-stream master side with end-of-frame marker.
interface gaussian_filter_3x3_if #(
  parameter int PIXEL_BIT_WIDTH = 16
);
  logic signed [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA;
  logic                              pixel_in_TVALID;
  logic                              pixel_in_TREADY;
  logic signed [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA;
  logic                              pixel_out_TVALID;
  logic                              pixel_out_TREADY;
  logic                              pixel_out_TLAST;

  modport master (
    output pixel_in_TDATA, pixel_in_TVALID, pixel_out_TREADY,
    input  pixel_in_TREADY, pixel_out_TDATA, pixel_out_TVALID, pixel_out_TLAST
  );

  modport slave (
    input  pixel_in_TDATA, pixel_in_TVALID, pixel_out_TREADY,
    output pixel_in_TREADY, pixel_out_TDATA, pixel_out_TVALID, pixel_out_TLAST
  );
endinterface

// File: rtl/gaussian_filter_3x3.sv
// Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) over a raster frame,
// emitting the valid-region result through a single skid-free output register.
module gaussian_filter_3x3 #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int ROWS             = 48,
  parameter int COLS             = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input logic                 clk,
  input logic                 reset,
  gaussian_filter_3x3_if.slave px
);
  localparam int W   = PIXEL_BIT_WIDTH;
  localparam int SW  = W + 4;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef logic signed [W-1:0]  pix_t;
  typedef logic signed [SW-1:0] acc_t;

  localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_LAST = IMG_ROW_BITWIDTH'(ROWS - 1);
  localparam logic [IMG_COL_BITWIDTH-1:0] COL_LAST = IMG_COL_BITWIDTH'(COLS - 1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_TWO  = IMG_ROW_BITWIDTH'(2);
  localparam logic [IMG_COL_BITWIDTH-1:0] COL_TWO  = IMG_COL_BITWIDTH'(2);
  localparam pix_t PIX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam pix_t PIX_MIN = {1'b1, {(W-1){1'b0}}};

  function automatic acc_t sx(input pix_t p);
    return acc_t'(p);
  endfunction

  // Floor division by 16; the clamp never engages for a normalised kernel.
  function automatic pix_t floor_div16(input acc_t s);
    acc_t sh;
    sh = s >>> 4;
    if (sh > sx(PIX_MAX))      return PIX_MAX;
    else if (sh < sx(PIX_MIN)) return PIX_MIN;
    else                       return pix_t'(sh);
  endfunction

  logic [IMG_ROW_BITWIDTH-1:0] row_q, row_d;
  logic [IMG_COL_BITWIDTH-1:0] col_q, col_d;
  pix_t                        lb0_q [COLS];
  pix_t                        lb1_q [COLS];
  pix_t                        win_q [3][2];
  pix_t                        win_d [3][2];
  pix_t                        tap   [3];
  logic [CIW-1:0]              idx;
  logic                        in_rdy, accept, produce, last_pix;
  acc_t                        acc;
  logic                        vld_q, vld_d, last_q, last_d;
  pix_t                        dat_q, dat_d;

  assign idx      = col_q[CIW-1:0];
  assign in_rdy   = !vld_q || px.pixel_out_TREADY;
  assign accept   = px.pixel_in_TVALID && in_rdy;
  assign produce  = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Incoming column: top row from the older line buffer, bottom from the stream.
  assign tap[0] = lb1_q[idx];
  assign tap[1] = lb0_q[idx];
  assign tap[2] = px.pixel_in_TDATA;

  assign px.pixel_in_TREADY  = in_rdy;
  assign px.pixel_out_TDATA  = dat_q;
  assign px.pixel_out_TVALID = vld_q;
  assign px.pixel_out_TLAST  = last_q;

  always_comb begin
    acc = sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(tap[0])
        + (sx(win_q[1][0]) <<< 1) + (sx(win_q[1][1]) <<< 2) + (sx(tap[1]) <<< 1)
        + sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(tap[2]);
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = tap[r];
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    last_d = last_q;
    if (produce) begin
      vld_d  = 1'b1;
      dat_d  = floor_div16(acc);
      last_d = last_pix;
    end else if (px.pixel_out_TREADY) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 2; k++) win_q[r][k] <= '0;
      end
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      last_q <= last_d;
      win_q  <= win_d;
    end
  end

  // Line buffers hold no state that matters after reset, so they stay unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[idx] <= lb0_q[idx];
      lb0_q[idx] <= px.pixel_in_TDATA;
    end
  end
endmodule

// File: tb/tb_gaussian_filter_3x3.sv
// Scoreboard bench: a 4x4 instance for hand-computed kernel cases and a 48x48
// instance for ramp frames with random handshakes, a stall and a mid-frame reset.
module tb_gaussian_filter_3x3;
  localparam int W = 16;
  localparam int N = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gaussian_filter_3x3_if #(.PIXEL_BIT_WIDTH(W)) bs ();
  gaussian_filter_3x3_if #(.PIXEL_BIT_WIDTH(W)) bd ();

  gaussian_filter_3x3 #(
    .PIXEL_BIT_WIDTH(W), .ROWS(4), .COLS(4), .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)
  ) dut_s (.clk(clk), .reset(rst_n), .px(bs));

  gaussian_filter_3x3 #(
    .PIXEL_BIT_WIDTH(W), .ROWS(N), .COLS(N), .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)
  ) dut_d (.clk(clk), .reset(rst_n), .px(bd));

  typedef struct {
    logic signed [W-1:0] d;
    logic                last;
  } exp_t;

  exp_t sb_s[$];
  exp_t sb_d[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_out_d  = 0;
  int   rdy_mode = 0;
  int   cur_r    = -1;
  int   cur_c    = -1;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_s(input int d, input bit last);
    exp_t e;
    e.d = W'(d);
    e.last = last;
    sb_s.push_back(e);
  endtask

  task automatic push_d(input int d, input bit last);
    exp_t e;
    e.d = W'(d);
    e.last = last;
    sb_d.push_back(e);
  endtask

  // Output monitors: a transfer is seen mid-cycle and completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bs.pixel_out_TVALID === 1'b1 && bs.pixel_out_TREADY === 1'b1) begin
      if (sb_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected: got output %0d expected none", bs.pixel_out_TDATA);
      end else begin
        exp_t e;
        e = sb_s.pop_front();
        chk("small_data", bs.pixel_out_TDATA, e.d);
        chk("small_last", bs.pixel_out_TLAST, e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bd.pixel_out_TVALID === 1'b1 && bd.pixel_out_TREADY === 1'b1) begin
      n_out_d++;
      if (sb_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL big_unexpected: got output %0d expected none", bd.pixel_out_TDATA);
      end else begin
        exp_t e;
        e = sb_d.pop_front();
        chk("big_data", bd.pixel_out_TDATA, e.d);
        chk("big_last", bd.pixel_out_TLAST, e.last);
      end
    end
  end

  initial begin
    bd.pixel_out_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bd.pixel_out_TREADY = 1'b1;
        1:       bd.pixel_out_TREADY = 1'($urandom_range(0, 1));
        default: bd.pixel_out_TREADY = 1'b0;
      endcase
    end
  end

  task automatic send_s(input logic signed [W-1:0] v);
    int t = 0;
    bs.pixel_in_TDATA  = v;
    bs.pixel_in_TVALID = 1'b1;
    @(negedge clk);
    while (bs.pixel_in_TREADY !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL small_in_timeout: got TREADY %0b expected 1", bs.pixel_in_TREADY);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame_s(input int kind);
    logic signed [W-1:0] v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kind == 0)      v = 100;
        else if (kind == 1) v = (r == 1 && c == 1) ? 16'sd16 : 16'sd0;
        else                v = (r == 1 && c == 1) ? -16'sd1 : 16'sd0;
        send_s(v);
        if (kind == 0 && r == 2 && c == 1) chk("lat_before", bs.pixel_out_TVALID, 0);
        if (kind == 0 && r == 2 && c == 2) begin
          chk("lat_valid", bs.pixel_out_TVALID, 1);
          chk("lat_data", bs.pixel_out_TDATA, 100);
        end
      end
    end
  endtask

  task automatic send_d(input int r, input int c, input bit rnd);
    int t = 0;
    if (rnd) begin
      while ($urandom_range(0, 1) == 0) begin
        bd.pixel_in_TVALID = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bd.pixel_in_TDATA  = W'(N * r + c);
    bd.pixel_in_TVALID = 1'b1;
    if (r >= 2 && c >= 2) push_d(N * (r - 1) + (c - 1), (r == N - 1) && (c == N - 1));
    @(negedge clk);
    while (bd.pixel_in_TREADY !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL big_in_timeout: got TREADY %0b expected 1", bd.pixel_in_TREADY);
    end
    @(posedge clk);
    #1;
    cur_r = r;
    cur_c = c;
  endtask

  task automatic frame_d(input bit rnd, input int n_in);
    for (int i = 0; i < n_in; i++) send_d(i / N, i % N, rnd);
    bd.pixel_in_TVALID = 1'b0;
  endtask

  task automatic stall_check();
    int t = 0;
    while (!(cur_r == 10 && cur_c == 20) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL stall_wait: got position %0d,%0d expected 10,20", cur_r, cur_c);
    end else begin
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk("stall_valid", bd.pixel_out_TVALID, 1);
        chk("stall_in_ready", bd.pixel_in_TREADY, 0);
        if (sb_d.size() > 0) chk("stall_data", bd.pixel_out_TDATA, sb_d[0].d);
        else chk("stall_queue", sb_d.size(), 1);
      end
      rdy_mode = 0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb_s.size() != 0 || sb_d.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_small_left"}, sb_s.size(), 0);
    chk({name, "_big_left"}, sb_d.size(), 0);
  endtask

  initial begin
    rst_n               = 1'b0;
    bs.pixel_in_TDATA   = '0;
    bs.pixel_in_TVALID  = 1'b0;
    bs.pixel_out_TREADY = 1'b1;
    bd.pixel_in_TDATA   = '0;
    bd.pixel_in_TVALID  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", bs.pixel_out_TVALID, 0);
    chk("rst_s_data", bs.pixel_out_TDATA, 0);
    chk("rst_s_last", bs.pixel_out_TLAST, 0);
    chk("rst_s_in_ready", bs.pixel_in_TREADY, 1);
    chk("rst_d_valid", bd.pixel_out_TVALID, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 frames back to back: flat, positive impulse, negative impulse.
    for (int k = 0; k < 4; k++) push_s(100, k == 3);
    push_s(4, 0); push_s(2, 0); push_s(2, 0); push_s(1, 1);
    for (int k = 0; k < 4; k++) push_s(-1, k == 3);
    frame_s(0);
    frame_s(1);
    frame_s(2);
    bs.pixel_in_TVALID = 1'b0;
    drain("small");

    // Ramp frame with random input valid and random output ready.
    n_out_d  = 0;
    rdy_mode = 1;
    frame_d(1, N * N);
    drain("ramp_rand");
    rdy_mode = 0;
    chk("ramp_rand_count", n_out_d, (N - 2) * (N - 2));

    // Ramp frame with a 20-cycle downstream stall mid-row.
    n_out_d = 0;
    fork
      frame_d(0, N * N);
      stall_check();
    join
    drain("ramp_stall");
    chk("ramp_stall_count", n_out_d, (N - 2) * (N - 2));

    // Partial frame, reset mid-frame, then a full ramp frame.
    frame_d(0, 1000);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bd.pixel_out_TVALID, 0);
    chk("midrst_last", bd.pixel_out_TLAST, 0);
    chk("midrst_data", bd.pixel_out_TDATA, 0);
    repeat (2) @(posedge clk);
    sb_d.delete();
    n_out_d = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    frame_d(1, N * N);
    drain("ramp_after_rst");
    rdy_mode = 0;
    chk("ramp_after_rst_count", n_out_d, (N - 2) * (N - 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
